// File: rtl/rps_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rps_pkg
// Description : Shared move/outcome encodings, FSM state codes and the
//               round-judging function for the rock-paper-scissors game
//               round controller and the move predictors.
// Revision    : 1.0  initial release
// ============================================================================
package rps_pkg;

  // Move encoding shared with the predictor
  localparam logic [1:0] MV_ROCK     = 2'b00;
  localparam logic [1:0] MV_SCISSORS = 2'b01;
  localparam logic [1:0] MV_PAPER    = 2'b10;
  localparam logic [1:0] MV_ILLEGAL  = 2'b11;

  // Round outcome, seen from the player's side
  localparam logic [1:0] RES_TIE  = 2'b00;
  localparam logic [1:0] RES_WIN  = 2'b01;
  localparam logic [1:0] RES_LOSE = 2'b10;

  // Round sequencer states
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_WAIT   = 3'd1;
  localparam logic [2:0] ST_COMMIT = 3'd2;
  localparam logic [2:0] ST_SCORE  = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  // Judge one round. Rock blunts scissors, scissors cut paper, paper wraps
  // rock. An illegal computer move falls through to RES_LOSE here; callers
  // that must treat it differently check for MV_ILLEGAL themselves.
  function automatic logic [1:0] judge(input logic [1:0] user,
                                       input logic [1:0] comp);
    logic [1:0] res;
    res = RES_LOSE;
    if (user == comp) begin
      res = RES_TIE;
    end else if ((user == MV_ROCK     && comp == MV_SCISSORS) ||
                 (user == MV_SCISSORS && comp == MV_PAPER)    ||
                 (user == MV_PAPER    && comp == MV_ROCK)) begin
      res = RES_WIN;
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rps_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : rps_scoreboard
// Description : Win/loss/tie and completed-round counters plus the
//               game-over flag. One outcome is booked per strobe; once the
//               game is over further strobes are ignored so nothing wraps.
// Revision    : 1.0  initial release
// ============================================================================
module rps_scoreboard
  import rps_pkg::*;
#(
  parameter int ROUNDS = 60,
  parameter int CW     = 6
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          i_strobe,
  input  logic [1:0]    i_result,
  output logic [CW-1:0] o_wins,
  output logic [CW-1:0] o_losses,
  output logic [CW-1:0] o_ties,
  output logic [CW-1:0] o_round_cnt,
  output logic          o_last_round,
  output logic          o_game_over
);

  localparam logic [CW-1:0] LAST_ROUND = CW'(ROUNDS - 1);

  logic [CW-1:0] r_wins;
  logic [CW-1:0] r_losses;
  logic [CW-1:0] r_ties;
  logic [CW-1:0] r_round_cnt;
  logic          r_game_over;
  logic          w_last_round;

  // The round being scored now is the final one of the game
  assign w_last_round = (r_round_cnt == LAST_ROUND);

  // Book exactly one outcome and one round per accepted strobe
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_wins      <= '0;
      r_losses    <= '0;
      r_ties      <= '0;
      r_round_cnt <= '0;
      r_game_over <= 1'b0;
    end else if (i_strobe && !r_game_over) begin
      case (i_result)
        RES_WIN:  r_wins   <= r_wins + 1'b1;
        RES_LOSE: r_losses <= r_losses + 1'b1;
        default:  r_ties   <= r_ties + 1'b1;
      endcase
      r_round_cnt <= r_round_cnt + 1'b1;
      if (w_last_round) begin
        r_game_over <= 1'b1;
      end
    end
  end

  assign o_wins       = r_wins;
  assign o_losses     = r_losses;
  assign o_ties       = r_ties;
  assign o_round_cnt  = r_round_cnt;
  assign o_last_round = w_last_round;
  assign o_game_over  = r_game_over;

endmodule
`default_nettype wire

// File: rtl/rps_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rps_round_ctrl
// Description : Game-round sequencer. Takes debounced key presses, runs the
//               start/ready handshake with the move predictor, captures the
//               computer move, judges the round and feeds the scoreboard.
// Revision    : 1.0  initial release
// ============================================================================
module rps_round_ctrl
  import rps_pkg::*;
#(
  parameter int ROUNDS  = 60,
  parameter int TIMEOUT = 255,
  parameter int CW      = 6
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          key_valid,
  input  logic [1:0]    key_move,
  output logic [1:0]    pred_user,
  output logic          pred_start,
  input  logic          pred_ready,
  input  logic [1:0]    pred_choice,
  output logic [1:0]    comp_move,
  output logic [1:0]    result,
  output logic          result_valid,
  output logic [CW-1:0] wins,
  output logic [CW-1:0] losses,
  output logic [CW-1:0] ties,
  output logic [CW-1:0] round_cnt,
  output logic          game_over,
  output logic          busy,
  output logic          err
);

  // The timer only has to hold 0 .. TIMEOUT-1 while waiting
  localparam int              TW         = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [TW-1:0]   TIMER_LAST = TW'(TIMEOUT - 1);

  logic [2:0]    r_state;
  logic [TW-1:0] r_timer;
  logic [1:0]    r_pred_user;
  logic          r_pred_start;
  logic [1:0]    r_comp_move;
  logic [1:0]    r_result;
  logic          r_result_valid;
  logic          r_err;

  logic          w_score;
  logic          w_comp_illegal;
  logic [1:0]    w_outcome;
  logic          w_last_round;
  logic          w_game_over;

  // An illegal predictor move is flagged and the round counts as a tie
  assign w_comp_illegal = (r_comp_move == MV_ILLEGAL);
  assign w_outcome      = w_comp_illegal ? RES_TIE : judge(r_pred_user, r_comp_move);
  assign w_score        = (r_state == ST_SCORE);

  // Round sequencer: handshake, capture, judge and sticky error tracking
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state        <= ST_IDLE;
      r_timer        <= '0;
      r_pred_user    <= MV_ROCK;
      r_pred_start   <= 1'b0;
      r_comp_move    <= MV_ROCK;
      r_result       <= RES_TIE;
      r_result_valid <= 1'b0;
      r_err          <= 1'b0;
    end else begin
      r_result_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (key_valid) begin
            if (key_move == MV_ILLEGAL) begin
              r_err <= 1'b1;
            end else if (!w_game_over) begin
              r_pred_user  <= key_move;
              r_timer      <= '0;
              r_pred_start <= 1'b1;
              r_state      <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          r_timer <= r_timer + 1'b1;
          // A ready on the very last allowed cycle still wins over timeout
          if (pred_ready) begin
            r_comp_move <= pred_choice;
            r_state     <= ST_COMMIT;
          end else if (r_timer == TIMER_LAST) begin
            r_err        <= 1'b1;
            r_pred_start <= 1'b0;
            r_state      <= ST_IDLE;
          end
        end
        ST_COMMIT: begin
          // Falling edge of start tells the predictor to commit its update
          r_pred_start <= 1'b0;
          r_state      <= ST_SCORE;
        end
        ST_SCORE: begin
          r_result       <= w_outcome;
          r_result_valid <= 1'b1;
          if (w_comp_illegal) begin
            r_err <= 1'b1;
          end
          r_state <= w_last_round ? ST_DONE : ST_IDLE;
        end
        ST_DONE: begin
          r_state <= ST_DONE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  rps_scoreboard #(
    .ROUNDS (ROUNDS),
    .CW     (CW)
  ) u_scoreboard (
    .clock        (clock),
    .reset        (reset),
    .i_strobe     (w_score),
    .i_result     (w_outcome),
    .o_wins       (wins),
    .o_losses     (losses),
    .o_ties       (ties),
    .o_round_cnt  (round_cnt),
    .o_last_round (w_last_round),
    .o_game_over  (w_game_over)
  );

  assign pred_user    = r_pred_user;
  assign pred_start   = r_pred_start;
  assign comp_move    = r_comp_move;
  assign result       = r_result;
  assign result_valid = r_result_valid;
  assign game_over    = w_game_over;
  assign busy         = (r_state != ST_IDLE) && (r_state != ST_DONE);
  assign err          = r_err;

endmodule
`default_nettype wire
